// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and pipeline-control signals of the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Instruction fetch port
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  i_ack;
   // Load/store port
   logic                  d_req;
   logic                  d_wen;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_ack;
   // Shared memory port
   logic                  m_cs;
   logic                  m_we;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic [DATA_WIDTH-1:0] m_rdata;
   logic                  m_ack;
   // Pipeline control
   logic                  if_stall;
   logic                  mem_stall;
   logic                  bus_err;

   modport slave (
      input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_ack, d_rdata, d_ack, m_cs, m_we, m_addr, m_wdata,
             if_stall, mem_stall, bus_err
   );

   modport master (
      output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_ack, d_rdata, d_ack, m_cs, m_we, m_addr, m_wdata,
             if_stall, mem_stall, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store:
// data first, bounded data streak while a fetch waits, per-access ack timeout.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam int PORT_I   = 0;
   localparam int PORT_D   = 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
   localparam logic [7:0]          TMO_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t                     state_reg, state_next;
   logic                       m_cs_reg, m_cs_next;
   logic                       m_we_reg, m_we_next;
   logic [ADDR_WIDTH-1:0]      m_addr_reg, m_addr_next;
   logic [DATA_WIDTH-1:0]      m_wdata_reg, m_wdata_next;
   logic [1:0]                 ack_reg, ack_next;
   logic [1:0][DATA_WIDTH-1:0] rdata_reg, rdata_next;
   logic [STREAK_W-1:0]        streak_reg, streak_next;
   logic [7:0]                 tmo_reg, tmo_next;
   logic                       bus_err_reg, bus_err_next;

   logic       d_wins;
   logic       gnt_port;
   logic       done;
   logic       timed_out;
   logic [1:0] req;
   logic [1:0] stall;

   assign req       = {bus.d_req, bus.i_req};
   assign d_wins    = bus.d_req && (!bus.i_req || (streak_reg < STREAK_MAX));
   assign gnt_port  = (state_reg == GNT_D);
   // A real ack on the last allowed cycle still wins over the timeout
   assign done      = (state_reg != IDLE) && (bus.m_ack || (tmo_reg == TMO_LAST));
   assign timed_out = (state_reg != IDLE) && !bus.m_ack && (tmo_reg == TMO_LAST);

   always_comb begin
      state_next   = state_reg;
      m_cs_next    = m_cs_reg;
      m_we_next    = m_we_reg;
      m_addr_next  = m_addr_reg;
      m_wdata_next = m_wdata_reg;
      ack_next     = '0;
      rdata_next   = rdata_reg;
      streak_next  = streak_reg;
      tmo_next     = tmo_reg;
      bus_err_next = bus_err_reg;

      unique case (state_reg)
         IDLE: begin
            if (d_wins) begin
               state_next   = GNT_D;
               m_cs_next    = 1'b1;
               m_we_next    = bus.d_wen;
               m_addr_next  = bus.d_addr;
               m_wdata_next = bus.d_wdata;
               tmo_next     = '0;
               if (bus.i_req) begin
                  streak_next = (streak_reg == STREAK_MAX) ? streak_reg
                                                           : streak_reg + STREAK_W'(1);
               end else begin
                  streak_next = '0;
               end
            end else if (bus.i_req) begin
               state_next   = GNT_I;
               m_cs_next    = 1'b1;
               m_we_next    = 1'b0;
               m_addr_next  = bus.i_addr;
               m_wdata_next = '0;
               tmo_next     = '0;
               streak_next  = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (done) begin
               state_next           = IDLE;
               m_cs_next            = 1'b0;
               m_we_next            = 1'b0;
               ack_next[gnt_port]   = 1'b1;
               rdata_next[gnt_port] = (timed_out || m_we_reg) ? '0 : bus.m_rdata;
               if (timed_out) begin
                  bus_err_next = 1'b1;
               end
            end else begin
               tmo_next = tmo_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            m_cs_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         m_cs_reg    <= 1'b0;
         m_we_reg    <= 1'b0;
         m_addr_reg  <= '0;
         m_wdata_reg <= '0;
         ack_reg     <= '0;
         rdata_reg   <= '0;
         streak_reg  <= '0;
         tmo_reg     <= '0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         m_cs_reg    <= m_cs_next;
         m_we_reg    <= m_we_next;
         m_addr_reg  <= m_addr_next;
         m_wdata_reg <= m_wdata_next;
         ack_reg     <= ack_next;
         rdata_reg   <= rdata_next;
         streak_reg  <= streak_next;
         tmo_reg     <= tmo_next;
         bus_err_reg <= bus_err_next;
      end
   end

   // Stalls are combinational so the pipeline releases in the ack cycle itself
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign stall[gi] = req[gi] & ~ack_reg[gi];
      end
   endgenerate

   assign bus.i_ack     = ack_reg[PORT_I];
   assign bus.d_ack     = ack_reg[PORT_D];
   assign bus.i_rdata   = rdata_reg[PORT_I];
   assign bus.d_rdata   = rdata_reg[PORT_D];
   assign bus.if_stall  = stall[PORT_I];
   assign bus.mem_stall = stall[PORT_D];
   assign bus.m_cs      = m_cs_reg;
   assign bus.m_we      = m_we_reg;
   assign bus.m_addr    = m_addr_reg;
   assign bus.m_wdata   = m_wdata_reg;
   assign bus.bus_err   = bus_err_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of
// the arbitration, streak, timeout and memory contents.
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst_n;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MAX_D_STREAK(MAXS),
      .TIMEOUT     (TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   // Reference model state
   bit            i_pend, d_pend, d_wen_q;
   logic [AW-1:0] i_addr_q, d_addr_q;
   logic [DW-1:0] d_wdata_q;
   int            streak;
   bit            err;
   logic [DW-1:0] mem [logic [AW-1:0]];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return 32'h100 + (32'($urandom_range(0, 15)) << 2);
   endfunction

   task automatic drive();
      bus.i_req   = i_pend;
      bus.i_addr  = i_addr_q;
      bus.d_req   = d_pend;
      bus.d_wen   = d_wen_q;
      bus.d_addr  = d_addr_q;
      bus.d_wdata = d_wdata_q;
   endtask

   task automatic new_i(input logic [AW-1:0] a);
      i_pend   = 1'b1;
      i_addr_q = a;
   endtask

   task automatic new_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      d_pend    = 1'b1;
      d_wen_q   = we;
      d_addr_q  = a;
      d_wdata_q = wd;
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         bus.m_ack   = 1'($urandom_range(0, 1));
         bus.m_rdata = $urandom;
         @(posedge clk); #1;
         chk("idle_cs", bus.m_cs, 1'b0);
         chk("idle_ack", {bus.i_ack, bus.d_ack}, 2'b00);
         chk("idle_stall", {bus.if_stall, bus.mem_stall}, 2'b00);
      end
      bus.m_ack = 1'b0;
   endtask

   // One memory access: memory acks k cycles after m_cs rises (never if k >= TMO).
   // Called during a cycle in which the arbiter is idle and something is pending.
   task automatic run_txn(input int k, output bit won_d);
      bit            ewe, tmo;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew, erd;
      won_d = d_pend && (!i_pend || streak < MAXS);
      if (won_d) begin
         streak = i_pend ? ((streak < MAXS) ? streak + 1 : streak) : 0;
         ea = d_addr_q; ewe = d_wen_q; ew = d_wdata_q;
      end else begin
         streak = 0;
         ea = i_addr_q; ewe = 1'b0; ew = '0;
      end
      erd = ewe ? '0 : mem_rd(ea);

      @(posedge clk); #1;
      chk("grant_cs", bus.m_cs, 1'b1);
      chk("grant_addr", bus.m_addr, ea);
      chk("grant_we", bus.m_we, ewe);
      if (ewe) chk("grant_wdata", bus.m_wdata, ew);
      chk("grant_noack", {bus.i_ack, bus.d_ack}, 2'b00);
      chk("grant_if_stall", bus.if_stall, i_pend);
      chk("grant_mem_stall", bus.mem_stall, d_pend);

      tmo = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         bus.m_ack   = (c == k);
         bus.m_rdata = (c == k && !ewe) ? erd : $urandom;
         @(posedge clk); #1;
         if (c == k) break;
         if (c == TMO - 1) begin
            tmo = 1'b1;
            break;
         end
         chk("wait_cs", bus.m_cs, 1'b1);
         chk("wait_addr", bus.m_addr, ea);
         chk("wait_noack", {bus.i_ack, bus.d_ack}, 2'b00);
      end
      // Stray ack while nothing is granted must be ignored
      bus.m_ack   = 1'($urandom_range(0, 1));
      bus.m_rdata = $urandom;

      if (tmo) begin
         err = 1'b1;
         erd = '0;
      end else if (ewe) begin
         mem[ea] = ew;
      end
      chk("done_cs", bus.m_cs, 1'b0);
      chk("i_ack", bus.i_ack, !won_d);
      chk("d_ack", bus.d_ack, won_d);
      if (won_d) chk("d_rdata", bus.d_rdata, erd);
      else       chk("i_rdata", bus.i_rdata, erd);
      chk("bus_err", bus.bus_err, err);
      chk("ack_if_stall", bus.if_stall, won_d ? i_pend : 1'b0);
      chk("ack_mem_stall", bus.mem_stall, won_d ? 1'b0 : d_pend);
      $display("TXN %0d port=%s addr=%08h we=%0d lat=%0d tmo=%0d rdata=%08h bus_err=%0d",
               n_txn, won_d ? "D" : "I", ea, ewe, k, tmo,
               won_d ? bus.d_rdata : bus.i_rdata, bus.bus_err);
      n_txn++;
      if (won_d) d_pend = 1'b0;
      else       i_pend = 1'b0;
      drive();
   endtask

   task automatic drain();
      bit w;
      for (int g = 0; g < 4 && (i_pend || d_pend); g++) run_txn(1, w);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit            w;
      logic [5:0]    seq;
      int            r, k;

      i_pend = 0; d_pend = 0; d_wen_q = 0;
      i_addr_q = '0; d_addr_q = '0; d_wdata_q = '0;
      streak = 0; err = 0;
      drive();
      bus.m_ack = 1'b0; bus.m_rdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {bus.m_cs, bus.m_we, bus.i_ack, bus.d_ack, bus.bus_err}, 5'b0);
      chk("rst_addr", bus.m_addr, 32'h0);
      chk("rst_wdata", bus.m_wdata, 32'h0);
      chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
      rst_n = 1'b1;
      idle_cycles(2);

      // T1 single fetch
      mem[32'h40] = 32'h2002_0005;
      new_i(32'h40); drive();
      run_txn(1, w);
      chk("t1_i_rdata", bus.i_rdata, 64'h2002_0005);
      idle_cycles(1);

      // T2 store then load
      new_d(1'b1, 32'h100, 32'hDEAD_BEEF); drive();
      run_txn(1, w);
      new_d(1'b0, 32'h100, 32'h0); drive();
      run_txn(1, w);
      chk("t2_d_rdata", bus.d_rdata, 64'hDEAD_BEEF);
      idle_cycles(1);

      // T3 contention: data first, fetch right after
      new_i(32'h44); new_d(1'b0, 32'h104, 32'h0); drive();
      run_txn(1, w);
      chk("t3_first_d", w, 1'b1);
      run_txn(1, w);
      chk("t3_second_i", w, 1'b0);
      idle_cycles(1);

      // T4 starvation limit: D D D D I D
      new_i(32'h48); new_d(1'b0, rand_addr(), 32'h0); drive();
      seq = '0;
      for (int j = 0; j < 6; j++) begin
         run_txn(1, w);
         seq[j] = w;
         if (j < 5) begin
            if (w) new_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            else   new_i(32'h4C);
            drive();
         end
      end
      chk("t4_order", seq, 6'b101111);
      drain();
      idle_cycles(1);

      // T5 timeout, boundary ack on the last cycle, sticky bus_err
      new_d(1'b0, 32'h200, 32'h0); drive();
      run_txn(TMO + 10, w);
      chk("t5_err", bus.bus_err, 1'b1);
      new_i(32'h50); drive();
      run_txn(TMO - 1, w);
      new_d(1'b0, 32'h100, 32'h0); drive();
      run_txn(1, w);
      chk("t5_err_sticky", bus.bus_err, 1'b1);
      idle_cycles(1);

      // T6 reset in the middle of a data access
      new_d(1'b1, 32'h300, 32'hCAFE_F00D); drive();
      @(posedge clk); #1;
      chk("t6_granted", bus.m_cs, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ctrl", {bus.m_cs, bus.m_we, bus.i_ack, bus.d_ack, bus.bus_err}, 5'b0);
      chk("t6_rst_addr", bus.m_addr, 32'h0);
      chk("t6_rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
      err = 1'b0; streak = 0;
      @(posedge clk); #1;
      chk("t6_no_ack", {bus.d_ack, bus.m_cs}, 2'b00);
      rst_n = 1'b1;
      run_txn(1, w);
      chk("t6_regrant_d", w, 1'b1);
      idle_cycles(1);

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         if (!i_pend && $urandom_range(0, 2) != 0) new_i(rand_addr());
         if (!d_pend && $urandom_range(0, 2) != 0)
            new_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
         drive();
         if (!i_pend && !d_pend) begin
            idle_cycles(int'($urandom_range(1, 2)));
         end else begin
            r = int'($urandom_range(0, 19));
            k = (r < 16) ? int'($urandom_range(0, 3)) : (r < 18) ? TMO - 1 : TMO + 4;
            run_txn(k, w);
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
